// File: rtl/wb_initiator_arbiter.sv
// Round-robin arbiter sharing one Wishbone target port between N_INIT initiators.
// The grant is locked for the whole CYC period. A watchdog raises a one-cycle ERR
// toward the granted initiator when a strobed beat stalls for TIMEOUT cycles.
module wb_initiator_arbiter #(
  parameter int unsigned N_INIT     = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_INIT*ADDR_WIDTH-1:0]   i_adr,
  input  logic [N_INIT*DATA_WIDTH-1:0]   i_dat_w,
  output logic [DATA_WIDTH-1:0]          i_dat_r,
  input  logic [N_INIT*DATA_WIDTH/8-1:0] i_sel,
  input  logic [N_INIT-1:0]              i_stb,
  input  logic [N_INIT-1:0]              i_cyc,
  input  logic [N_INIT-1:0]              i_we,
  output logic [N_INIT-1:0]              i_ack,
  output logic [N_INIT-1:0]              i_err,
  output logic [ADDR_WIDTH-1:0]          t_adr,
  output logic [DATA_WIDTH-1:0]          t_dat_w,
  input  logic [DATA_WIDTH-1:0]          t_dat_r,
  output logic [DATA_WIDTH/8-1:0]        t_sel,
  output logic                           t_stb,
  output logic                           t_cyc,
  output logic                           t_we,
  input  logic                           t_ack,
  input  logic                           t_err,
  output logic [N_INIT-1:0]              gnt
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam int unsigned WDOG_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_INIT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q;
  logic [N_INIT-1:0]   gnt_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [WDOG_W-1:0]   wdog_q;

  logic                busy;
  logic                wdog_fire;
  logic [WDOG_W-1:0]   wdog_d;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [N_INIT-1:0]   pick_onehot;
  logic [IDX_W-1:0]    rr_next;

  assign busy = (state_q == StBusy);
  assign gnt  = gnt_q;

  // Pick the first requester at or after rr_ptr, wrapping modulo N_INIT.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int unsigned off = 0; off < N_INIT; off++) begin
      cand = (32'(rr_ptr_q) + off) % N_INIT;
      if (!pick_valid && i_cyc[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
    pick_onehot[pick_idx] = 1'b1;
    rr_next = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
  end

  // Route the granted slice to the target; the data/address mux keeps the last grant when idle.
  always_comb begin
    t_adr   = i_adr[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
    t_dat_w = i_dat_w[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    t_sel   = i_sel[gidx_q*SEL_WIDTH +: SEL_WIDTH];
    t_cyc   = busy & i_cyc[gidx_q];
    t_stb   = busy & i_stb[gidx_q];
    t_we    = busy & i_we[gidx_q];
    i_dat_r = t_dat_r;
    i_ack   = '0;
    i_err   = '0;
    if (busy && i_cyc[gidx_q] && i_stb[gidx_q]) begin
      i_ack[gidx_q] = t_ack;
      i_err[gidx_q] = t_err | wdog_fire;
    end
  end

  // Watchdog: count stalled strobed cycles; a target response always wins over the timeout.
  always_comb begin
    wdog_fire = (TIMEOUT != 0) && busy && t_stb && !t_ack && !t_err && (wdog_q == WDOG_LAST);
    wdog_d    = '0;
    if ((TIMEOUT != 0) && busy && t_stb && !t_ack && !t_err && !wdog_fire) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // Grant FSM: lock the grant for the whole CYC period, then force one idle cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      wdog_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wdog_q <= '0;
          if (pick_valid) begin
            state_q <= StBusy;
            gidx_q  <= pick_idx;
            gnt_q   <= pick_onehot;
          end
        end
        StBusy: begin
          wdog_q <= wdog_d;
          if (!i_cyc[gidx_q]) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            rr_ptr_q <= rr_next;
            wdog_q   <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator_arbiter.sv
module tb_wb_initiator_arbiter;

  logic        clk;
  logic        reset;
  logic [63:0] i_adr;
  logic [63:0] i_dat_w;
  logic [31:0] i_dat_r;
  logic [7:0]  i_sel;
  logic [1:0]  i_stb;
  logic [1:0]  i_cyc;
  logic [1:0]  i_we;
  logic [1:0]  i_ack;
  logic [1:0]  i_err;
  logic [31:0] t_adr;
  logic [31:0] t_dat_w;
  logic [31:0] t_dat_r;
  logic [3:0]  t_sel;
  logic        t_stb;
  logic        t_cyc;
  logic        t_we;
  logic        t_ack;
  logic        t_err;
  logic [1:0]  gnt;

  wb_initiator_arbiter #(
    .N_INIT    (2),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .clock  (clk),
    .reset  (reset),
    .i_adr  (i_adr),
    .i_dat_w(i_dat_w),
    .i_dat_r(i_dat_r),
    .i_sel  (i_sel),
    .i_stb  (i_stb),
    .i_cyc  (i_cyc),
    .i_we   (i_we),
    .i_ack  (i_ack),
    .i_err  (i_err),
    .t_adr  (t_adr),
    .t_dat_w(t_dat_w),
    .t_dat_r(t_dat_r),
    .t_sel  (t_sel),
    .t_stb  (t_stb),
    .t_cyc  (t_cyc),
    .t_we   (t_we),
    .t_ack  (t_ack),
    .t_err  (t_err),
    .gnt    (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic       err;
    logic [1:0] e_gnt;
    logic       e_tcyc;
    logic       e_tstb;
    logic [1:0] e_ack;
    logic [1:0] e_err;
    logic       chk;
    logic       src_chk;
    logic       src;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Per-initiator static bus values used to check routing.
  logic [31:0] exp_adr [2] = '{32'h0000_0100, 32'h0000_0200};
  logic [31:0] exp_dat [2] = '{32'hDEAD_BEEF, 32'h1234_5678};
  logic [3:0]  exp_sel [2] = '{4'hF, 4'h3};
  logic        exp_we  [2] = '{1'b1, 1'b0};

  function automatic void add(input logic r, input logic [1:0] c, input logic [1:0] s,
                              input logic a, input logic e, input logic [1:0] g,
                              input logic tc, input logic ts, input logic [1:0] ia,
                              input logic [1:0] ie, input logic ck, input logic sc,
                              input logic src);
    vec_t v;
    v = '{r, c, s, a, e, g, tc, ts, ia, ie, ck, sc, src};
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] c, input logic [1:0] s,
                       input logic a, input logic e);
    reset = r;
    i_cyc = c;
    i_stb = s;
    t_ack = a;
    t_err = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_adr   = {exp_adr[1], exp_adr[0]};
    i_dat_w = {exp_dat[1], exp_dat[0]};
    i_sel   = {exp_sel[1], exp_sel[0]};
    i_we    = 2'b01;
    t_dat_r = 32'hCAFE_F00D;
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);

    //   rst cyc   stb   ack err gnt   tcyc tstb iack  ierr  chk src_chk src
    add(1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    add(1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    // single write from init0, ack one cycle after stb
    add(0, 2'b01, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b01, 2'b01, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00, 1, 1, 0);
    add(0, 2'b01, 2'b01, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 1, 1, 0);
    add(0, 2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    // reset brings rr_ptr back to 0; simultaneous requests
    add(1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 1, 1, 0);
    add(0, 2'b10, 2'b10, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b10, 2'b10, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b10, 2'b10, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 1, 1, 1);
    add(0, 2'b00, 2'b00, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    // init0 alone moves rr_ptr to 1, then a tie goes to init1
    add(0, 2'b01, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b01, 2'b01, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 1, 1, 0);
    add(0, 2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    // init1 locks the bus for 4 acked beats while init0 waits
    add(0, 2'b11, 2'b11, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 1, 1, 1);
    add(0, 2'b11, 2'b11, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 1, 1, 1);
    add(0, 2'b11, 2'b11, 0, 0, 2'b10, 1, 1, 2'b00, 2'b00, 1, 1, 1);
    add(0, 2'b11, 2'b11, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 1, 1, 1);
    add(0, 2'b11, 2'b11, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 1, 1, 1);
    add(0, 2'b01, 2'b01, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b01, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    // ack+err together pass through; dropped STB keeps the grant and masks ack
    add(0, 2'b01, 2'b01, 1, 1, 2'b01, 1, 1, 2'b01, 2'b01, 1, 1, 0);
    add(0, 2'b01, 2'b00, 1, 0, 2'b01, 1, 0, 2'b00, 2'b00, 1, 1, 0);
    add(0, 2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].cyc, vq[i].stb, vq[i].ack, vq[i].err);
      @(negedge clk);
      if (vq[i].chk) begin
        chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vq[i].e_gnt));
        chk($sformatf("v%0d t_cyc", i), 32'(t_cyc), 32'(vq[i].e_tcyc));
        chk($sformatf("v%0d t_stb", i), 32'(t_stb), 32'(vq[i].e_tstb));
        chk($sformatf("v%0d i_ack", i), 32'(i_ack), 32'(vq[i].e_ack));
        chk($sformatf("v%0d i_err", i), 32'(i_err), 32'(vq[i].e_err));
      end
      if (vq[i].src_chk) begin
        chk($sformatf("v%0d t_adr", i), t_adr, exp_adr[vq[i].src]);
        chk($sformatf("v%0d t_dat_w", i), t_dat_w, exp_dat[vq[i].src]);
        chk($sformatf("v%0d t_sel", i), 32'(t_sel), 32'(exp_sel[vq[i].src]));
        chk($sformatf("v%0d t_we", i), 32'(t_we), 32'(exp_we[vq[i].src]));
      end
      tick();
    end
    chk("i_dat_r broadcast", i_dat_r, 32'hCAFE_F00D);

    // Watchdog: init1 stalls, err fires on stall cycles 16 and 32 (rr_ptr is 1 here).
    drive(1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) chk("wd gnt", 32'(gnt), 32'h2);
      chk($sformatf("wd k%0d i_err", k), 32'(i_err), (k == 16 || k == 32) ? 32'h2 : 32'h0);
      tick();
    end
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    tick();

    // Ack arriving on the would-be firing cycle wins over the watchdog.
    drive(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 17; k++) begin
      t_ack = (k == 16);
      @(negedge clk);
      chk($sformatf("ack16 k%0d i_err", k), 32'(i_err), 32'h0);
      chk($sformatf("ack16 k%0d i_ack", k), 32'(i_ack), (k == 16) ? 32'h1 : 32'h0);
      tick();
    end
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    tick();

    // Reset mid-beat with rr_ptr at 1: late ack ignored, re-arbitration from 0.
    drive(1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b01, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst pre gnt", 32'(gnt), 32'h1);
    chk("rst pre t_cyc", 32'(t_cyc), 32'h1);
    tick();
    drive(1'b0, 2'b11, 2'b11, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst post gnt", 32'(gnt), 32'h0);
    chk("rst post t_cyc", 32'(t_cyc), 32'h0);
    chk("rst post i_ack", 32'(i_ack), 32'h0);
    tick();
    drive(1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    chk("rearb gnt", 32'(gnt), 32'h1);
    chk("rearb t_adr", t_adr, 32'h0000_0100);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
